// File: rtl/irq_pkg.sv
// Shared types and constants for the four-source interrupt controller.
package irq_pkg;

  localparam int IRQ_N    = 4;
  localparam int IRQ_ID_W = 2;
  localparam int GAP_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } irq_state_e;

  function automatic logic [IRQ_N-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    return IRQ_N'(1) << id;
  endfunction

endpackage

// File: rtl/encoder_4to2.sv
// Priority encoder: highest set input bit wins, valid_o flags any set bit.
module encoder_4to2 (
  input  logic [3:0] in_i,
  output logic [1:0] out_o,
  output logic       valid_o
);

  always_comb begin
    out_o   = 2'd0;
    valid_o = 1'b1;
    casez (in_i)
      4'b1???: out_o = 2'd3;
      4'b01??: out_o = 2'd2;
      4'b001?: out_o = 2'd1;
      4'b0001: out_o = 2'd0;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/irq_ctrl_4.sv
// Four-source interrupt controller: edge-captured sticky pending bits,
// masked highest-index selection, and a valid/ack service handshake.
module irq_ctrl_4 import irq_pkg::*; #(
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IRQ_N-1:0]    req,
  input  logic [IRQ_N-1:0]    mask,
  input  logic                ack,
  input  logic                clr_overrun,
  output logic                irq_valid,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic [IRQ_N-1:0]    pending,
  output logic [IRQ_N-1:0]    overrun
);

  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  logic [IRQ_N-1:0]    req_q;
  logic [IRQ_N-1:0]    pending_q, pending_d;
  logic [IRQ_N-1:0]    overrun_q, overrun_d;
  logic                valid_q, valid_d;
  logic [IRQ_ID_W-1:0] id_q, id_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  irq_state_e          state_q, state_d;

  logic [IRQ_N-1:0]    req_edge;
  logic [IRQ_N-1:0]    clr_vec;
  logic [IRQ_ID_W-1:0] sel_id;
  logic                any_req;

  encoder_4to2 u_enc (
    .in_i   (pending_q & mask),
    .out_o  (sel_id),
    .valid_o(any_req)
  );

  assign req_edge = req & ~req_q;
  assign clr_vec  = (state_q == SERVE && ack) ? id_onehot(id_q) : '0;

  // A new event beats a same-cycle clear, and is not an overrun in that case.
  assign pending_d = req_edge | (pending_q & ~clr_vec);
  assign overrun_d = (req_edge & pending_q & ~clr_vec) | (clr_overrun ? '0 : overrun_q);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    id_d      = id_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          id_d    = sel_id;
          valid_d = 1'b1;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (ack) begin
          valid_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      gap_cnt_q <= '0;
      state_q   <= IDLE;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      gap_cnt_q <= gap_cnt_d;
      state_q   <= state_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_irq_ctrl_4.sv
// Self-checking bench for irq_ctrl_4: vector table through a scoreboard,
// plus async-reset and zero-gap back-to-back sequences.
module tb_irq_ctrl_4;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       clr;
    logic       v;
    logic [1:0] id;
    logic [3:0] p;
    logic [3:0] o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'h0, mask = 4'hF;
  logic       ack = 1'b0, clr_overrun = 1'b0;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [3:0] pending, overrun;

  logic [3:0] req0 = 4'h0, mask0 = 4'hF;
  logic       ack0 = 1'b0, clr0 = 1'b0;
  logic       irq_valid0;
  logic [1:0] irq_id0;
  logic [3:0] pending0, overrun0;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t vecs[$];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  irq_ctrl_4 #(.GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
    .clr_overrun(clr_overrun), .irq_valid(irq_valid), .irq_id(irq_id),
    .pending(pending), .overrun(overrun)
  );

  irq_ctrl_4 #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .mask(mask0), .ack(ack0),
    .clr_overrun(clr0), .irq_valid(irq_valid0), .irq_id(irq_id0),
    .pending(pending0), .overrun(overrun0)
  );

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] m, input logic a,
                              input logic c, input logic v, input logic [1:0] id,
                              input logic [3:0] p, input logic [3:0] o);
    vec_t t;
    t.req = r; t.mask = m; t.ack = a; t.clr = c;
    t.v = v; t.id = id; t.p = p; t.o = o;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s: value %h", nm, act);
    end else begin
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t vv, input string nm);
    vec_t e;
    @(negedge clk);
    req = vv.req; mask = vv.mask; ack = vv.ack; clr_overrun = vv.clr;
    sb_q.push_back(vv);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk(nm, {21'd0, irq_valid, irq_id, pending, overrun}, {21'd0, e.v, e.id, e.p, e.o});
  endtask

  initial begin
    // Expected fields: valid, id, pending, overrun after the edge the inputs precede.
    // Basic single source with one-cycle gap
    vecs.push_back(mk(4'b0001, 4'hF, 0, 0, 0, 2'd0, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd0, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 4'b0000));
    // Simultaneous 0101: id 2 first, then id 0
    vecs.push_back(mk(4'b0101, 4'hF, 0, 0, 0, 2'd0, 4'b0101, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd2, 4'b0101, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 2'd2, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 2'd2, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd0, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 4'b0000));
    // Masked source 3 waits until unmasked
    vecs.push_back(mk(4'b1010, 4'h7, 0, 0, 0, 2'd0, 4'b1010, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'h7, 0, 0, 1, 2'd1, 4'b1010, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'h7, 1, 0, 0, 2'd1, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'h7, 0, 0, 0, 2'd1, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'h7, 0, 0, 0, 2'd1, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd3, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 2'd3, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 2'd3, 4'b0000, 4'b0000));
    // Higher-priority arrival during SERVE does not change the ID
    vecs.push_back(mk(4'b0010, 4'hF, 0, 0, 0, 2'd3, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b1000, 4'hF, 0, 0, 1, 2'd1, 4'b1010, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd1, 4'b1010, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 2'd1, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 2'd1, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd3, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 2'd3, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 2'd3, 4'b0000, 4'b0000));
    // Overrun, edge coincident with ack, clr_overrun, set beats clear
    vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 2'd3, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 4'b0100));
    vecs.push_back(mk(4'b0100, 4'hF, 1, 0, 0, 2'd2, 4'b0100, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'hF, 0, 1, 1, 2'd2, 4'b0100, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 2'd2, 4'b0000, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 2'd2, 4'b0000, 4'b0000));
    // ack outside SERVE is ignored
    vecs.push_back(mk(4'b0001, 4'hF, 1, 0, 0, 2'd2, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 1, 2'd0, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 2'd0, 4'b0000, 4'b0000));
    // Masking during SERVE does not revoke the grant
    vecs.push_back(mk(4'b1000, 4'hF, 0, 0, 0, 2'd0, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd3, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd3, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 0, 2'd3, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 2'd3, 4'b0000, 4'b0000));
    // Set up SERVE with pending and overrun for the async reset check
    vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 2'd3, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 4'b0100));

    #12;
    chk("reset_state", {21'd0, irq_valid, irq_id, pending, overrun}, 32'd0);
    chk("reset_state_gap0", {21'd0, irq_valid0, irq_id0, pending0, overrun0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset mid-SERVE, with req held high through reset release
    #2;
    rst_n = 1'b0;
    req = 4'b0001;
    #1;
    chk("async_rst_valid", {31'd0, irq_valid}, 32'd0);
    chk("async_rst_pending", {28'd0, pending}, 32'd0);
    chk("async_rst_overrun", {28'd0, overrun}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("held_req_edge", {28'd0, pending}, 32'd1);
    @(negedge clk);
    req = 4'b0000;

    // Zero-gap build: grants separated by exactly one idle cycle
    begin
      logic [3:0] r_seq[6];
      logic       a_seq[6];
      logic [6:0] e_seq[6];
      logic [6:0] got;
      r_seq = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      a_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      e_seq = '{{1'b0, 2'd0, 4'b0011}, {1'b1, 2'd1, 4'b0011}, {1'b0, 2'd1, 4'b0001},
                {1'b1, 2'd0, 4'b0001}, {1'b0, 2'd0, 4'b0000}, {1'b0, 2'd0, 4'b0000}};
      for (int k = 0; k < 6; k++) begin
        vec_t t;
        @(negedge clk);
        req0 = r_seq[k];
        ack0 = a_seq[k];
        t = mk(r_seq[k], 4'hF, a_seq[k], 0, e_seq[k][6], e_seq[k][5:4], e_seq[k][3:0], 4'b0000);
        sb_q.push_back(t);
        @(posedge clk); #1;
        t = sb_q.pop_front();
        got = {irq_valid0, irq_id0, pending0};
        chk($sformatf("gap0_cyc%0d", k), {21'd0, got, overrun0}, {21'd0, t.v, t.id, t.p, t.o});
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
